// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: aligned load/store sequencer with sub-word extract, read-modify-write merge and misalignment rejection.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic [31:0] rdata
);
  typedef enum logic [2:0] {IDLE, REQ, CAP, WR, DONE, ERR} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d, sext_q, sext_d;
  logic        mem_wr_q, mem_wr_d, busy_q, busy_d, done_q, done_d, misalign_q, misalign_d;
  logic        mis_in;
  logic [4:0]  sh;
  logic [31:0] shifted, mask, loaded, merged;
  assign mis_in  = (size == 2'b00 && addr[1:0] != 2'b00) || (size == 2'b01 && addr[0]) || size == 2'b11;
  assign sh      = size_q[1] ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
  assign shifted = mem_rdata >> sh;
  assign mask    = size_q[1] ? 32'h0000_00FF : 32'h0000_FFFF;
  assign loaded  = size_q == 2'b10 ? {{24{sext_q & shifted[7]}}, shifted[7:0]} :
                   size_q == 2'b01 ? {{16{sext_q & shifted[15]}}, shifted[15:0]} : mem_rdata;
  assign merged  = (mem_rdata & ~(mask << sh)) | ((wdata_q & mask) << sh);
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    size_d      = size_q;
    sext_d      = sext_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: if (start) begin
        addr_d      = addr;
        wdata_d     = wdata;
        we_d        = we;
        size_d      = size;
        sext_d      = sign_ext;
        state_d     = mis_in ? ERR : REQ;
        mem_addr_d  = mis_in ? mem_addr_q : {addr[31:2], 2'b00};
        mem_wdata_d = (!mis_in && we && size == 2'b00) ? wdata : mem_wdata_q;
      end
      REQ: state_d = (we_q && size_q == 2'b00) ? DONE : CAP;
      CAP: begin
        state_d     = we_q ? WR : DONE;
        mem_wdata_d = we_q ? merged : mem_wdata_q;
        rdata_d     = we_q ? rdata_q : loaded;
      end
      WR:      state_d = DONE;
      default: state_d = IDLE;
    endcase
    busy_d     = state_d != IDLE;
    done_d     = state_d == DONE || state_d == ERR;
    misalign_d = state_d == ERR;
    // a word store writes straight from REQ; sub-word stores write only after the merge
    mem_wr_d   = state_d == WR || (state_d == REQ && we_d && size_d == 2'b00);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      sext_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      mem_wr_q    <= mem_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
    end
  end
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign misalign  = misalign_q;
  assign rdata     = rdata_q;
endmodule
